// File: rtl/avl_st_pkt_fifo.sv
// rtl/avl_st_pkt_fifo.sv - Avalon-ST packet FIFO with framing checker and orphan-drop counter
// Show-ahead FIFO; beats are tagged with an error flag when framing is broken.
module avl_st_pkt_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int SYMBOL_WIDTH  = 8,
  parameter int DEPTH         = 16,
  parameter int CHANNEL_WIDTH = 1,
  parameter int CNT_WIDTH     = 8,
  localparam int SYMBOLS      = DATA_WIDTH / SYMBOL_WIDTH,
  localparam int EMPTY_WIDTH  = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1,
  localparam int LVL_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [EMPTY_WIDTH-1:0]   in_empty,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [EMPTY_WIDTH-1:0]   out_empty,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_error,
  output logic [LVL_WIDTH-1:0]     fill_level,
  output logic [CNT_WIDTH-1:0]     drop_count
);
  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int ENTRY_WIDTH = 3 + EMPTY_WIDTH + CHANNEL_WIDTH + DATA_WIDTH;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                   state_q, state_d;
  logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_WIDTH-1:0]     count_q, count_d;
  logic [CNT_WIDTH-1:0]     drop_q, drop_d;
  logic [CHANNEL_WIDTH-1:0] pkt_ch_q, pkt_ch_d;
  logic                     ready_q, ready_d;
  logic [ENTRY_WIDTH-1:0]   mem_q [DEPTH];

  logic                     accept, push, pop, beat_err, head_valid;
  logic [EMPTY_WIDTH-1:0]   empty_st;
  logic [ENTRY_WIDTH-1:0]   entry_d, head;

  assign head_valid = (count_q != '0);
  assign accept     = in_valid & ready_q;
  assign pop        = head_valid & out_ready;
  assign empty_st   = in_endofpacket ? in_empty : '0;
  assign entry_d    = {in_startofpacket, in_endofpacket, beat_err, empty_st, in_channel, in_data};

  always_comb begin
    state_d  = state_q;
    pkt_ch_d = pkt_ch_q;
    drop_d   = drop_q;
    push     = 1'b0;
    beat_err = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_startofpacket) begin
            push     = 1'b1;
            pkt_ch_d = in_channel;
            state_d  = in_endofpacket ? IDLE : IN_PKT;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
        IN_PKT: begin
          // A fresh sop inside a packet restarts framing but is still flagged.
          push     = 1'b1;
          beat_err = in_startofpacket | (in_channel != pkt_ch_q);
          if (in_startofpacket) pkt_ch_d = in_channel;
          state_d  = in_endofpacket ? IDLE : IN_PKT;
        end
        default: state_d = IDLE;
      endcase
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // Ready looks only at the next registered level, so a pop at full frees a slot one cycle later.
    ready_d  = (count_d < LVL_WIDTH'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      pkt_ch_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      pkt_ch_q <= pkt_ch_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  // Storage is not reset, so the head is masked to zero whenever nothing is held.
  assign head = head_valid ? mem_q[rd_ptr_q] : '0;

  assign in_ready   = ready_q;
  assign out_valid  = head_valid;
  assign fill_level = count_q;
  assign drop_count = drop_q;
  assign {out_startofpacket, out_endofpacket, out_error, out_empty, out_channel, out_data} = head;

endmodule

// File: tb/tb_avl_st_pkt_fifo.sv
// tb/tb_avl_st_pkt_fifo.sv - self-checking bench for avl_st_pkt_fifo
module tb_avl_st_pkt_fifo;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_empty = '0;
  logic        in_channel = 1'b0;

  logic        in_ready, out_valid, out_sop, out_eop, out_channel, out_error;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic [4:0]  fill_level;
  logic [7:0]  drop_count;

  logic        in_ready2, out_valid2, out_sop2, out_eop2, out_channel2, out_error2;
  logic [31:0] out_data2;
  logic [1:0]  out_empty2;
  logic [4:0]  fill_level2;
  logic [1:0]  drop_count2;

  always #5 clk = ~clk;

  avl_st_pkt_fifo #(.DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(16), .CHANNEL_WIDTH(1), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_data(in_data), .in_empty(in_empty),
    .in_channel(in_channel), .out_ready(out_ready), .out_valid(out_valid),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_data(out_data),
    .out_empty(out_empty), .out_channel(out_channel), .out_error(out_error),
    .fill_level(fill_level), .drop_count(drop_count));

  avl_st_pkt_fifo #(.DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(16), .CHANNEL_WIDTH(1), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready2), .in_valid(in_valid),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_data(in_data), .in_empty(in_empty),
    .in_channel(in_channel), .out_ready(out_ready), .out_valid(out_valid2),
    .out_startofpacket(out_sop2), .out_endofpacket(out_eop2), .out_data(out_data2),
    .out_empty(out_empty2), .out_channel(out_channel2), .out_error(out_error2),
    .fill_level(fill_level2), .drop_count(drop_count2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d,
                       input logic [1:0] em, input logic c);
    in_valid = v; in_sop = s; in_eop = e; in_data = d; in_empty = em; in_channel = c;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    reset_n = 1'b0;
    tick; tick;
    chk("rst_outputs", {in_ready, out_valid, out_sop, out_eop, out_data, out_empty, out_channel, out_error}, 0);
    chk("rst_fill_drop", {fill_level, drop_count}, 0);
    chk("rst_dut2", {in_ready2, out_valid2, out_sop2, out_eop2, out_data2, out_empty2,
                     out_channel2, out_error2, fill_level2, drop_count2}, 0);
    reset_n = 1'b1;
    #1 chk("rst_release_ready_low", in_ready, 0);
    tick;
    chk("rst_ready_rises", in_ready, 1);
  endtask

  typedef struct {
    logic        vld, sop, eop;
    logic [31:0] data;
    logic [1:0]  empty;
    logic        ch;
    logic        e_ov;
    logic [1:0]  e_empty;
    logic        e_err;
    int          e_fill, e_drop;
  } vec_t;

  function automatic vec_t mk(logic v, logic s, logic e, logic [31:0] d, logic [1:0] em, logic c,
                              logic ov, logic [1:0] eem, logic err, int fill, int drop);
    vec_t r;
    r.vld = v; r.sop = s; r.eop = e; r.data = d; r.empty = em; r.ch = c;
    r.e_ov = ov; r.e_empty = eem; r.e_err = err; r.e_fill = fill; r.e_drop = drop;
    return r;
  endfunction

  typedef struct packed {
    logic sop, eop;
    logic [31:0] data;
    logic [1:0] empty;
    logic ch, err;
  } ent_t;

  ent_t mq[$];
  bit   m_in_pkt;
  logic m_ch;
  int   m_drop;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   rd;
    logic ch_r;

    do_reset;

    // Pass-through rows with out_ready=1: each stored beat appears after its edge, then pops.
    tbl.push_back(mk(1,1,1,32'hA5A5A5A5,2,1, 1,2,0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,        0,0,0,0,0));
    tbl.push_back(mk(1,0,0,32'h1,0,0,        0,0,0,0,1));
    tbl.push_back(mk(1,0,0,32'h2,0,0,        0,0,0,0,2));
    tbl.push_back(mk(1,0,1,32'h3,1,0,        0,0,0,0,3));
    tbl.push_back(mk(1,1,0,32'h10,3,0,       1,0,0,1,3));
    tbl.push_back(mk(1,0,0,32'h11,2,0,       1,0,0,1,3));
    tbl.push_back(mk(1,1,0,32'h12,0,0,       1,0,1,1,3));
    tbl.push_back(mk(1,0,1,32'h13,1,0,       1,1,0,1,3));
    tbl.push_back(mk(1,1,0,32'h20,0,0,       1,0,0,1,3));
    tbl.push_back(mk(1,0,0,32'h21,0,1,       1,0,1,1,3));
    tbl.push_back(mk(1,0,1,32'h22,3,0,       1,3,0,1,3));
    tbl.push_back(mk(0,0,0,32'h0,0,0,        0,0,0,0,3));
    tbl.push_back(mk(1,0,0,32'h40,0,0,       0,0,0,0,4));
    tbl.push_back(mk(1,1,0,32'h30,0,1,       1,0,0,1,4));
    tbl.push_back(mk(1,1,1,32'h31,2,1,       1,2,1,1,4));
    tbl.push_back(mk(1,0,0,32'h32,0,1,       0,0,0,0,5));

    out_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].sop, tbl[i].eop, tbl[i].data, tbl[i].empty, tbl[i].ch);
      tick;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_fill", i), fill_level, tbl[i].e_fill);
      chk($sformatf("tbl%0d_drop", i), drop_count, tbl[i].e_drop);
      if (tbl[i].e_ov)
        chk($sformatf("tbl%0d_beat", i), {out_sop, out_eop, out_data, out_empty, out_channel, out_error},
            {tbl[i].sop, tbl[i].eop, tbl[i].data, tbl[i].e_empty, tbl[i].ch, tbl[i].e_err});
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("drop_sat_cnt2", drop_count2, 3);

    // Fill to DEPTH with out_ready low; the write pointer crosses its wrap point here.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, i == 15, 32'h200 + i, 0, 0);
      tick;
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_fill", fill_level, 16);
    chk("full_head", {out_valid, out_data}, {1'b1, 32'h200});
    drive(1, 0, 0, 32'hDEAD, 0, 0);
    tick;
    chk("full_no_accept", {fill_level, drop_count}, {5'd16, 8'd5});
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("pop_ready_back", in_ready, 1);
    chk("pop_fill", fill_level, 15);
    tick;
    chk("stall_stable", out_data, 32'h201);
    out_ready = 1'b1;
    for (int j = 1; j < 16; j++) begin
      chk($sformatf("wrap_beat%0d", j), {out_valid, out_eop, out_error, out_data},
          {1'b1, j == 15, 1'b0, 32'h200 + j});
      tick;
    end
    chk("wrap_drained", {out_valid, fill_level}, 0);

    // Hold level at 5 while pushing and popping every cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 0, 32'h300 + i, 0, 0);
      tick;
    end
    chk("steady_fill_init", fill_level, 5);
    rd = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, i == 9, 32'h305 + i, 0, 0);
      chk($sformatf("steady_head%0d", i), out_data, 32'h300 + rd);
      tick;
      rd++;
      chk($sformatf("steady_fill%0d", i), fill_level, 5);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15 && rd < 15; k++) begin
      chk($sformatf("steady_drain%0d", rd), {out_valid, out_data}, {1'b1, 32'h300 + rd});
      tick;
      rd++;
    end
    chk("steady_empty", {out_valid, fill_level}, 0);

    // Asynchronous reset in the middle of a packet.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, 0, 32'h400 + i, 0, 0);
      tick;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst_fill_before", fill_level, 4);
    #2 reset_n = 1'b0;
    #1 chk("midrst_immediate", {in_ready, out_valid, fill_level, drop_count}, 0);
    tick;
    reset_n = 1'b1;
    tick;
    chk("midrst_ready", in_ready, 1);
    drive(1, 0, 0, 32'h404, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst_orphan", {out_valid, fill_level, drop_count}, {1'b0, 5'd0, 8'd1});

    // Randomised traffic against a queue model.
    do_reset;
    mq.delete();
    m_in_pkt = 0;
    m_ch = 1'b0;
    m_drop = 0;
    ch_r = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit   m_rdy, do_pop;
      ent_t e;
      int   pct;
      m_rdy = (mq.size() < 16);
      chk("rnd_in_ready", in_ready, m_rdy);
      chk("rnd_level", {out_valid, fill_level}, {mq.size() > 0, 5'(mq.size())});
      chk("rnd_drop", drop_count, m_drop);
      if (mq.size() > 0)
        chk("rnd_beat", {out_sop, out_eop, out_data, out_empty, out_channel, out_error}, mq[0]);

      pct = (cyc < 1500) ? 35 : 80;
      if ($urandom_range(0, 7) == 0) ch_r = ~ch_r;
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom, 2'($urandom), ch_r);
      out_ready = ($urandom_range(0, 99) < pct);

      do_pop = (mq.size() > 0) && out_ready;
      if (m_rdy && in_valid) begin
        e = '{sop: in_sop, eop: in_eop, data: in_data, empty: in_eop ? in_empty : 2'd0,
              ch: in_channel, err: 1'b0};
        if (!m_in_pkt) begin
          if (in_sop) begin
            mq.push_back(e);
            m_ch = in_channel;
            m_in_pkt = !in_eop;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end else begin
          e.err = in_sop || (in_channel != m_ch);
          mq.push_back(e);
          if (in_sop) m_ch = in_channel;
          m_in_pkt = !in_eop;
        end
      end
      if (do_pop) void'(mq.pop_front());
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
